// File: rtl/char_glyph_render.sv
// Purpose : text-mode pixel stage; 4x5 font ROM lookup per character cell, RGB plus delayed syncs.
// Latency : exactly 2 clk from inputs to rgb/video_on_out/hsync_out/vsync_out.
// Backpressure: none; free-running pixel stream, one pixel accepted and produced every clk.
//
// Ports:
//   clk, rst_n               pixel clock, async active-low reset
//   char_code[5:0]           character code for the current pixel (6'h3F = blank)
//   xcoor[9:0], ycoor[8:0]   pixel coordinates that produced char_code
//   video_on_in, hsync_in, vsync_in   active-video flag and active-low syncs
//   cursor_col[4:0]          cursor character column (cursor build only)
//   rgb[5:0]                 pixel colour RRGGBB
//   video_on_out, hsync_out, vsync_out   inputs delayed by 2 clk
//
// Optional feature: define CURSOR_BLINK_EN to build the blinking underline cursor.
module char_glyph_render #(
   parameter int         X_START      = 0,
   parameter int         Y_START      = 100,
   parameter int         N_CHARS      = 32,
   parameter logic [5:0] FG_COLOR     = 6'h3F,
   parameter logic [5:0] BG_COLOR     = 6'h00,
   parameter int         BLINK_FRAMES = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] char_code,
   input  logic [9:0] xcoor,
   input  logic [8:0] ycoor,
   input  logic       video_on_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic [4:0] cursor_col,
   output logic [5:0] rgb,
   output logic       video_on_out,
   output logic       hsync_out,
   output logic       vsync_out
);

   localparam logic [10:0] X_LO  = 11'(X_START);
   localparam logic [10:0] X_W   = 11'(4 * N_CHARS);
   localparam logic [9:0]  Y_LO  = 10'(Y_START);

   // Each glyph is five 4-bit rows packed top row first; bit3 of a row is the leftmost pixel.
   function automatic logic [19:0] font_glyph(input logic [5:0] code);
      logic [19:0] g;
      case (code)
         6'd0:  g = 20'h69996;
         6'd1:  g = 20'h26227;
         6'd2:  g = 20'hE168F;
         6'd3:  g = 20'hE161E;
         6'd4:  g = 20'h99F11;
         6'd5:  g = 20'hF8E1E;
         6'd6:  g = 20'h68E96;
         6'd7:  g = 20'hF1244;
         6'd8:  g = 20'h69696;
         6'd9:  g = 20'h69716;
         6'd10: g = 20'h69F99;  // A
         6'd11: g = 20'hE9E9E;
         6'd12: g = 20'h78887;
         6'd13: g = 20'hE999E;
         6'd14: g = 20'hF8E8F;
         6'd15: g = 20'hF8E88;
         6'd16: g = 20'h78B97;
         6'd17: g = 20'h99F99;
         6'd18: g = 20'h72227;
         6'd19: g = 20'h11196;
         6'd20: g = 20'h9ACA9;  // K
         6'd21: g = 20'h8888F;
         6'd22: g = 20'h9FF99;
         6'd23: g = 20'h9DB99;
         6'd24: g = 20'h69996;
         6'd25: g = 20'hE9E88;
         6'd26: g = 20'h699B7;
         6'd27: g = 20'hE9EA9;
         6'd28: g = 20'h7861E;
         6'd29: g = 20'hF2222;
         6'd30: g = 20'h99996;
         6'd31: g = 20'h999A4;
         6'd32: g = 20'h99FF9;
         6'd33: g = 20'h99699;
         6'd34: g = 20'h99716;
         6'd35: g = 20'hF168F;  // Z
         default: g = 20'h00000;
      endcase
      return g;
   endfunction

   // ---------------- stage 1: window decode ----------------
   logic [10:0] x_diff;
   logic [9:0]  y_diff;
   logic        in_win_d;
   logic [3:0]  row_d;

   // Subtracting the window origin lets a single unsigned compare cover both edges:
   // coordinates left of / above the origin wrap to large values.
   always_comb begin
      x_diff   = {1'b0, xcoor} - X_LO;
      y_diff   = {1'b0, ycoor} - Y_LO;
      in_win_d = (x_diff < X_W) && (y_diff <= 10'd5);
      row_d    = (y_diff > 10'd15) ? 4'hF : y_diff[3:0];
   end

   logic [5:0] code_q;
   logic [1:0] col_q;
   logic [3:0] row_q;
   logic       in_win_q;
   logic       vo_q;
   logic       hs_q;
   logic       vs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q   <= 6'h00;
         col_q    <= 2'd0;
         row_q    <= 4'd0;
         in_win_q <= 1'b0;
         vo_q     <= 1'b0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
      end else begin
         code_q   <= char_code;
         col_q    <= xcoor[1:0];
         row_q    <= row_d;
         in_win_q <= in_win_d;
         vo_q     <= video_on_in;
         hs_q     <= hsync_in;
         vs_q     <= vsync_in;
      end
   end

   // ---------------- cursor ----------------
   logic cursor_pix;

`ifdef CURSOR_BLINK_EN
   localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic          cur_hit_d;
   logic          cur_hit_q;
   logic          vs_fall;
   logic [CW-1:0] blink_cnt;
   logic          blink_phase;

   // Cell index is x_diff >> 2; out-of-range columns never match.
   assign cur_hit_d = (x_diff[10:2] == {4'b0000, cursor_col}) && (int'(cursor_col) < N_CHARS);

   // Falling edge seen between stage-1 vsync and its stage-2 copy.
   assign vs_fall = !vs_q && vsync_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_hit_q   <= 1'b0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         cur_hit_q <= cur_hit_d;
         if (vs_fall) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   assign cursor_pix = blink_phase && cur_hit_q && in_win_q && (row_q == 4'd5);
`else
   localparam int unused_blink_frames = BLINK_FRAMES;
   logic unused_cursor;
   assign unused_cursor = ^cursor_col;
   assign cursor_pix    = 1'b0;
`endif

   // ---------------- stage 2: glyph pixel and colour ----------------
   logic [19:0] glyph;
   logic [3:0]  bits;
   logic        pix;
   logic [5:0]  rgb_d;

   always_comb begin
      glyph = font_glyph(code_q);
      case (row_q[2:0])
         3'd0:    bits = glyph[19:16];
         3'd1:    bits = glyph[15:12];
         3'd2:    bits = glyph[11:8];
         3'd3:    bits = glyph[7:4];
         3'd4:    bits = glyph[3:0];
         default: bits = 4'h0;
      endcase
      pix   = (in_win_q && (row_q < 4'd5) && bits[2'd3 - col_q]) || cursor_pix;
      rgb_d = !vo_q ? 6'h00 : (pix ? FG_COLOR : BG_COLOR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb          <= 6'h00;
         video_on_out <= 1'b0;
         hsync_out    <= 1'b1;
         vsync_out    <= 1'b1;
      end else begin
         rgb          <= rgb_d;
         video_on_out <= vo_q;
         hsync_out    <= hs_q;
         vsync_out    <= vs_q;
      end
   end

endmodule

// File: tb/tb_char_glyph_render.sv
// Purpose : bench for char_glyph_render; directed pixels, expected outputs queued per vector.
// Latency : expects every output exactly 2 clk after the vector is applied.
// Backpressure: none; one vector per clk, monitor pops whatever is due each cycle.
module tb_char_glyph_render;

   localparam logic [5:0] FG = 6'h3F;
   localparam logic [5:0] BG = 6'h00;

`ifdef CURSOR_BLINK_EN
   localparam bit CURSOR_ON = 1'b1;
`else
   localparam bit CURSOR_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] char_code;
   logic [9:0] xcoor;
   logic [8:0] ycoor;
   logic       video_on_in;
   logic       hsync_in;
   logic       vsync_in;
   logic [4:0] cursor_col;
   logic [5:0] rgb;
   logic       video_on_out;
   logic       hsync_out;
   logic       vsync_out;

   always #5 clk = ~clk;

   char_glyph_render #(.BLINK_FRAMES(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .char_code    (char_code),
      .xcoor        (xcoor),
      .ycoor        (ycoor),
      .video_on_in  (video_on_in),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .cursor_col   (cursor_col),
      .rgb          (rgb),
      .video_on_out (video_on_out),
      .hsync_out    (hsync_out),
      .vsync_out    (vsync_out)
   );

   typedef struct {
      int          due;
      logic [8:0]  val;   // {rgb, video_on, hsync, vsync}
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_pass  = 0;
   int   n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got rgb=%h vo/hs/vs=%b, expected rgb=%h vo/hs/vs=%b",
                    name, act[8:3], act[2:0], exp[8:3], exp[2:0]);
   endtask

   // Monitor: compares the output word against every entry due this cycle.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
               n_total++;
               $display("FAIL %s: entry missed, due cycle %0d, now cycle %0d", e.name, e.due, cyc);
            end else begin
               check(e.name, {rgb, video_on_out, hsync_out, vsync_out}, e.val);
            end
         end
      end
   end

   task automatic apply(input string name, input logic [5:0] code, input int x, input int y,
                        input logic vo, input logic hs, input logic vs, input logic [5:0] exp_rgb);
      exp_t e;
      @(negedge clk);
      char_code   = code;
      xcoor       = 10'(x);
      ycoor       = 9'(y);
      video_on_in = vo;
      hsync_in    = hs;
      vsync_in    = vs;
      e.due  = cyc + 2;
      e.val  = {exp_rgb, vo, hs, vs};
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic idle();
      apply("idle", 6'h3F, 600, 300, 1'b0, 1'b1, 1'b1, 6'h00);
   endtask

   typedef struct {
      logic [5:0] code;
      int         y;
      int         xbase;
      logic [3:0] bits;
      string      name;
   } glyph_vec_t;

   logic [3:0] zero_rows [5];
   glyph_vec_t gv [4];

   initial begin : stim
      logic [5:0] er;
      logic       lit;

      zero_rows[0] = 4'b0110;
      zero_rows[1] = 4'b1001;
      zero_rows[2] = 4'b1001;
      zero_rows[3] = 4'b1001;
      zero_rows[4] = 4'b0110;

      gv[0] = '{code: 6'd10, y: 102, xbase: 20,  bits: 4'b1111, name: "glyph A r2"};
      gv[1] = '{code: 6'd20, y: 101, xbase: 8,   bits: 4'b1010, name: "glyph K r1"};
      gv[2] = '{code: 6'd35, y: 104, xbase: 124, bits: 4'b1111, name: "glyph Z r4 last cell"};
      gv[3] = '{code: 6'd36, y: 100, xbase: 0,   bits: 4'b0000, name: "code 36 blank"};

      rst_n       = 1'b0;
      char_code   = 6'h3F;
      xcoor       = 10'd600;
      ycoor       = 9'd300;
      video_on_in = 1'b1;
      hsync_in    = 1'b0;
      vsync_in    = 1'b0;
      cursor_col  = 5'd3;

      // Reset state
      repeat (3) @(negedge clk);
      #1 check("reset state", {rgb, video_on_out, hsync_out, vsync_out}, {6'h00, 1'b0, 1'b1, 1'b1});
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) idle();

      // Digit '0', all five rows and four columns
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 4; c++)
            apply($sformatf("glyph0 r%0d c%0d", r, c), 6'd0, c, 100 + r, 1'b1, 1'b1, 1'b1,
                  zero_rows[r][3 - c] ? FG : BG);

      // Letters and a code beyond Z
      for (int g = 0; g < 4; g++)
         for (int c = 0; c < 4; c++)
            apply($sformatf("%s c%0d", gv[g].name, c), gv[g].code, gv[g].xbase + c, gv[g].y,
                  1'b1, 1'b1, 1'b1, gv[g].bits[3 - c] ? FG : BG);

      // Latency: video_on/hsync toggle every cycle on a lit pixel
      for (int i = 0; i < 6; i++)
         apply($sformatf("latency toggle %0d", i), 6'd0, 1, 100, (i % 2) == 0, (i % 2) == 1,
               1'b1, ((i % 2) == 0) ? FG : 6'h00);

      // Bounds: position (1 mod 4) would be lit in row 0 of '0'
      apply("right of window x=129", 6'd0, 129, 100, 1'b1, 1'b1, 1'b1, BG);
      apply("above window y=99",     6'd0, 1,   99,  1'b1, 1'b1, 1'b1, BG);
      apply("below window y=106",    6'd0, 1,   106, 1'b1, 1'b1, 1'b1, BG);
      apply("gap row y=105",         6'd0, 1,   105, 1'b1, 1'b1, 1'b1, BG);
      apply("blank code 3F",         6'h3F, 1,  100, 1'b1, 1'b1, 1'b1, BG);
      apply("video off lit pixel",   6'd0, 1,   100, 1'b0, 1'b1, 1'b1, 6'h00);
      idle();

      // Mid-line reset: fill the pipe with non-reset values, then reset asynchronously
      apply("pre reset 0", 6'd0, 1, 100, 1'b1, 1'b0, 1'b0, FG);
      apply("pre reset 1", 6'd0, 1, 100, 1'b1, 1'b0, 1'b0, FG);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1 check("async reset mid-line", {rgb, video_on_out, hsync_out, vsync_out},
               {6'h00, 1'b0, 1'b1, 1'b1});
      char_code   = 6'h3F;
      xcoor       = 10'd600;
      ycoor       = 9'd300;
      video_on_in = 1'b0;
      hsync_in    = 1'b1;
      vsync_in    = 1'b1;
      @(negedge clk);
      check("reset held", {rgb, video_on_out, hsync_out, vsync_out}, {6'h00, 1'b0, 1'b1, 1'b1});
      rst_n = 1'b1;
      repeat (2) idle();

      // Cursor underline across six frames separated by vsync pulses
      for (int f = 0; f < 6; f++) begin
         lit = CURSOR_ON && (f == 2 || f == 3);
         for (int x = 12; x <= 16; x++) begin
            er = (lit && x < 16) ? FG : BG;
            apply($sformatf("cursor frame %0d x=%0d", f, x), 6'd0, x, 105, 1'b1, 1'b1, 1'b1, er);
         end
         apply($sformatf("cursor frame %0d video off", f), 6'd0, 13, 105, 1'b0, 1'b1, 1'b1, 6'h00);
         apply($sformatf("vsync pulse after frame %0d", f), 6'h3F, 600, 300, 1'b0, 1'b1, 1'b0, 6'h00);
         idle();
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         n_total++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
